// File: rtl/uart_pkg.sv
// Shared UART constants: data width and TX FIFO address width.
// Used as parameter defaults by the transmitter, FIFO and top level.
package uart_pkg;

  localparam int UART_DBITS          = 8;
  localparam int UART_FIFO_ADDR_BITS = 4;

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: 2^ADDR_BITS x DBITS register array.
// Ports: clk_100MHz, we, w_addr, w_data (sync write); r_addr, r_data (async read).
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DBITS     = UART_DBITS,
  parameter int ADDR_BITS = UART_FIFO_ADDR_BITS
) (
  input  logic                 clk_100MHz,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] w_addr,
  input  logic [DBITS-1:0]     w_data,
  input  logic [ADDR_BITS-1:0] r_addr,
  output logic [DBITS-1:0]     r_data
);

  logic [DBITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk_100MHz) begin
    if (we)
      mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through TX FIFO with registered count/full/empty flags
// and sticky overflow/underflow error flags.
// Ports: clk_100MHz, reset (sync, active-high), wr, w_data, rd, clear_err,
//        r_data, full, empty, count, overflow, underflow.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DBITS     = UART_DBITS,
  parameter int ADDR_BITS = UART_FIFO_ADDR_BITS
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [DBITS-1:0]     w_data,
  input  logic                 rd,
  input  logic                 clear_err,
  output logic [DBITS-1:0]     r_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ADDR_BITS:0] FULL_CNT =
    (ADDR_BITS+1)'(2**ADDR_BITS);

  logic [ADDR_BITS-1:0] w_ptr;
  logic [ADDR_BITS-1:0] r_ptr;
  logic [ADDR_BITS:0]   count_next;
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 ovf_set;
  logic                 unf_set;

  // A full FIFO still takes a write when the head is popped the same cycle.
  assign wr_ok   = wr & (~full | rd);
  assign rd_ok   = rd & ~empty;
  assign ovf_set = wr & full & ~rd;
  assign unf_set = rd & empty;

  always_comb begin
    count_next = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_next = count + (ADDR_BITS+1)'(1);
      2'b01:   count_next = count - (ADDR_BITS+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok)
        w_ptr <= w_ptr + ADDR_BITS'(1);
      if (rd_ok)
        r_ptr <= r_ptr + ADDR_BITS'(1);
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
      // Set beats clear when both occur together.
      overflow  <= ovf_set | (overflow & ~clear_err);
      underflow <= unf_set | (underflow & ~clear_err);
    end
  end

  uart_fifo_ram #(
    .DBITS     (DBITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk_100MHz (clk_100MHz),
    .we         (wr_ok),
    .w_addr     (w_ptr),
    .w_data     (w_data),
    .r_addr     (r_ptr),
    .r_data     (r_data)
  );

endmodule
